// File: rtl/b_router_pkg.sv
// Shared widths, header field positions and port indices for the b_router slice.
// Combinational constants only: no latency and no backpressure.
package b_router_pkg;
  localparam int HDR_W  = 28;
  localparam int DAT_W  = 128;
  localparam int NPORT  = 5;

  localparam int VLD_BIT = 27;
  localparam int DY_HI   = 23;
  localparam int DY_LO   = 20;
  localparam int DX_HI   = 19;
  localparam int DX_LO   = 16;
  localparam int AGE_HI  = 15;
  localparam int AGE_LO  = 0;

  localparam int PN = 0;
  localparam int PE = 1;
  localparam int PS = 2;
  localparam int PW = 3;
  localparam int PL = 4;

  localparam logic [2:0] P_NONE = 3'd7;

  typedef logic [HDR_W-1:0] hdr_t;
  typedef logic [DAT_W-1:0] dat_t;
endpackage

// File: rtl/b_router_route.sv
// Dimension-order (X then Y) productive-port lookup; purely combinational, 0 cycles.
// No backpressure: invalid headers yield no productive port and no local flag.
module b_router_route
  import b_router_pkg::*;
(
  input  logic [HDR_W-1:0] hdr,
  input  logic [3:0]       x,
  input  logic [3:0]       y,
  output logic [3:0]       prod_oh,
  output logic             is_local
);
  logic [3:0] dx;
  logic [3:0] dy;
  logic       unused_hdr_bits;

  assign dx = hdr[DX_HI:DX_LO];
  assign dy = hdr[DY_HI:DY_LO];
  assign unused_hdr_bits = ^{hdr[26:24], hdr[AGE_HI:AGE_LO]};

  always_comb begin
    prod_oh  = '0;
    is_local = 1'b0;
    if (hdr[VLD_BIT]) begin
      if (dx > x)      prod_oh[PE] = 1'b1;
      else if (dx < x) prod_oh[PW] = 1'b1;
      else if (dy > y) prod_oh[PS] = 1'b1;
      else if (dy < y) prod_oh[PN] = 1'b1;
      else             is_local    = 1'b1;
    end
  end
endmodule

// File: rtl/b_router.sv
// Oldest-first bufferless deflection router: headers 1 cycle, payload 1 cycle behind; AGE_INC_EN bumps age.
// Never stalls network flits; injection accepted (port4_ready) only when a network port is idle.
module b_router
  import b_router_pkg::*;
#(
  parameter int X = 0,
  parameter int Y = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [HDR_W-1:0]  port0_ci,
  input  logic [HDR_W-1:0]  port1_ci,
  input  logic [HDR_W-1:0]  port2_ci,
  input  logic [HDR_W-1:0]  port3_ci,
  input  logic [HDR_W-1:0]  port4_ci,
  input  logic [DAT_W-1:0]  port0_di,
  input  logic [DAT_W-1:0]  port1_di,
  input  logic [DAT_W-1:0]  port2_di,
  input  logic [DAT_W-1:0]  port3_di,
  input  logic [DAT_W-1:0]  port4_di,
  output logic [HDR_W-1:0]  port0_co,
  output logic [HDR_W-1:0]  port1_co,
  output logic [HDR_W-1:0]  port2_co,
  output logic [HDR_W-1:0]  port3_co,
  output logic [HDR_W-1:0]  port4_co,
  output logic [DAT_W-1:0]  port0_do,
  output logic [DAT_W-1:0]  port1_do,
  output logic [DAT_W-1:0]  port2_do,
  output logic [DAT_W-1:0]  port3_do,
  output logic [DAT_W-1:0]  port4_do,
  output logic              port4_ready
);
  localparam logic [3:0] XC = 4'(X);
  localparam logic [3:0] YC = 4'(Y);

  hdr_t       ci      [NPORT];
  dat_t       di      [NPORT];
  hdr_t       co_d    [NPORT];
  hdr_t       co_q    [NPORT];
  dat_t       do_d    [NPORT];
  dat_t       do_q    [NPORT];
  logic [2:0] sel_d   [NPORT];
  logic [2:0] sel_q   [NPORT];
  logic [3:0] prod_oh [NPORT];
  logic       is_local[NPORT];
  logic [2:0] rank    [4];
  logic [3:0] net_vld;

  assign ci = '{port0_ci, port1_ci, port2_ci, port3_ci, port4_ci};
  assign di = '{port0_di, port1_di, port2_di, port3_di, port4_di};

  for (genvar g = 0; g < NPORT; g++) begin : g_route
    b_router_route u_route (
      .hdr      (ci[g]),
      .x        (XC),
      .y        (YC),
      .prod_oh  (prod_oh[g]),
      .is_local (is_local[g])
    );
  end

  for (genvar g = 0; g < 4; g++) begin : g_vld
    assign net_vld[g] = ci[g][VLD_BIT];
  end

  assign port4_ready = ~&net_vld;

  function automatic hdr_t age_upd(hdr_t h);
    hdr_t r;
    r = h;
`ifdef AGE_INC_EN
    if (h[AGE_HI:AGE_LO] != 16'hFFFF) r[AGE_HI:AGE_LO] = h[AGE_HI:AGE_LO] + 16'd1;
`endif
    return r;
  endfunction

  // Productive port if free, else lowest free network port; port 4 only for eligible local flits.
  function automatic logic [2:0] pick(logic [3:0] prod, logic loc, logic [4:0] fr);
    logic [2:0] p;
    p = P_NONE;
    if (loc && fr[PL]) begin
      p = 3'(PL);
    end else begin
      for (int k = 3; k >= 0; k--) if (fr[k]) p = 3'(k);
      for (int k = 0; k < 4; k++) if (prod[k] && fr[k]) p = 3'(k);
    end
    return p;
  endfunction

  // rank 0 is the oldest valid network flit; ties resolve toward the lower input index.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      rank[i] = '0;
      for (int j = 0; j < 4; j++) begin
        if (j != i && net_vld[j] &&
            ((ci[j][AGE_HI:AGE_LO] > ci[i][AGE_HI:AGE_LO]) ||
             ((ci[j][AGE_HI:AGE_LO] == ci[i][AGE_HI:AGE_LO]) && (j < i))))
          rank[i] = rank[i] + 3'd1;
      end
    end
  end

  always_comb begin
    logic [4:0] free;
    logic [2:0] p;
    free = 5'b11111;
    p    = P_NONE;
    for (int k = 0; k < NPORT; k++) begin
      sel_d[k] = P_NONE;
      co_d[k]  = '0;
    end
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 4; i++) begin
        if (net_vld[i] && rank[i] == 3'(r)) begin
          p = pick(prod_oh[i], is_local[i], free);
          if (p != P_NONE) begin
            free[p]  = 1'b0;
            sel_d[p] = 3'(i);
            co_d[p]  = age_upd(ci[i]);
          end
        end
      end
    end
    if (port4_ready && ci[PL][VLD_BIT]) begin
      p = pick(prod_oh[PL], 1'b0, free);
      if (p != P_NONE) begin
        sel_d[p] = 3'(PL);
        co_d[p]  = age_upd(ci[PL]);
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NPORT; k++) begin
      do_d[k] = '0;
      if (sel_q[k] != P_NONE) do_d[k] = di[sel_q[k]];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NPORT; k++) begin
        co_q[k]  <= '0;
        do_q[k]  <= '0;
        sel_q[k] <= P_NONE;
      end
    end else begin
      for (int k = 0; k < NPORT; k++) begin
        co_q[k]  <= co_d[k];
        do_q[k]  <= do_d[k];
        sel_q[k] <= sel_d[k];
      end
    end
  end

  assign port0_co = co_q[0];
  assign port1_co = co_q[1];
  assign port2_co = co_q[2];
  assign port3_co = co_q[3];
  assign port4_co = co_q[4];
  assign port0_do = do_q[0];
  assign port1_do = do_q[1];
  assign port2_do = do_q[2];
  assign port3_do = do_q[3];
  assign port4_do = do_q[4];
endmodule

// File: tb/tb_b_router.sv
// Directed scoreboard bench for b_router at X=Y=0; expected ages follow AGE_INC_EN.
module tb_b_router;
  logic         clk = 1'b0;
  logic         rst;
  logic [27:0]  ci   [5];
  logic [127:0] di   [5];
  logic [27:0]  co   [5];
  logic [127:0] dq   [5];
  logic         rdy;
  int           checks = 0;
  int           errors = 0;

  logic [4:0][27:0]  co_exp_q[$];
  logic [4:0][127:0] do_exp_q[$];

  localparam logic [127:0] PAY = 128'h0123456789abcdef0123456789abcdef;
  localparam logic [127:0] PA  = {16{8'hA5}};
  localparam logic [127:0] PB  = {16{8'hB6}};
  localparam logic [127:0] PC  = {16{8'hC7}};
  localparam logic [127:0] PD  = {16{8'hD8}};
  localparam logic [127:0] PE  = {16{8'hE9}};
  localparam logic [127:0] Z   = 128'h0;
  localparam logic [27:0]  ZH  = 28'h0;

  b_router #(.X(0), .Y(0)) dut (
    .clk(clk), .rst(rst),
    .port0_ci(ci[0]), .port1_ci(ci[1]), .port2_ci(ci[2]), .port3_ci(ci[3]), .port4_ci(ci[4]),
    .port0_di(di[0]), .port1_di(di[1]), .port2_di(di[2]), .port3_di(di[3]), .port4_di(di[4]),
    .port0_co(co[0]), .port1_co(co[1]), .port2_co(co[2]), .port3_co(co[3]), .port4_co(co[4]),
    .port0_do(dq[0]), .port1_do(dq[1]), .port2_do(dq[2]), .port3_do(dq[3]), .port4_do(dq[4]),
    .port4_ready(rdy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [27:0] inc(logic [27:0] h);
`ifdef AGE_INC_EN
    if (h[15:0] != 16'hFFFF) h[15:0] = h[15:0] + 16'd1;
`endif
    return h;
  endfunction

  function automatic logic [4:0][27:0] h5(logic [27:0] a0, a1, a2, a3, a4);
    return {a4, a3, a2, a1, a0};
  endfunction

  function automatic logic [4:0][127:0] d5(logic [127:0] a0, a1, a2, a3, a4);
    return {a4, a3, a2, a1, a0};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("%s_co%0d", tag, k), {100'h0, co[k]}, Z);
      chk($sformatf("%s_do%0d", tag, k), dq[k], Z);
    end
  endtask

  task automatic step(input string tag,
                      input logic [4:0][27:0]  c,  input logic [4:0][127:0] d,
                      input logic [4:0][27:0]  eco, input logic [4:0][127:0] edo,
                      input logic erdy);
    logic [4:0][27:0]  ec;
    logic [4:0][127:0] ed;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      ci[k] = c[k];
      di[k] = d[k];
    end
    co_exp_q.push_back(eco);
    do_exp_q.push_back(edo);
    #1 chk({tag, "_ready"}, {127'h0, rdy}, {127'h0, erdy});
    @(posedge clk);
    #1;
    ec = co_exp_q.pop_front();
    ed = do_exp_q.pop_front();
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("%s_co%0d", tag, k), {100'h0, co[k]}, {100'h0, ec[k]});
      chk($sformatf("%s_do%0d", tag, k), dq[k], ed[k]);
    end
  endtask

  initial begin
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      ci[k] = '0;
      di[k] = '0;
    end
    // Reset held while inputs toggle.
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      for (int k = 0; k < 5; k++) begin
        ci[k] = 28'h8000000 | 28'($urandom);
        di[k] = {$urandom, $urandom, $urandom, $urandom};
      end
      #1 chk("rst_ready", {127'h0, rdy}, Z);
      @(posedge clk);
      #1 chk_zero("rst");
    end
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      ci[k] = '0;
      di[k] = '0;
    end
    rst = 1'b1;

    step("idle", h5(ZH, ZH, ZH, ZH, ZH), d5(Z, Z, Z, Z, Z),
         h5(ZH, ZH, ZH, ZH, ZH), d5(Z, Z, Z, Z, Z), 1'b1);

    step("contend", h5(28'h8000001, 28'h8040002, 28'h8090003, 28'h80f0004, ZH), d5(Z, Z, Z, Z, Z),
         h5(inc(28'h8090003), inc(28'h80f0004), inc(28'h8040002), ZH, inc(28'h8000001)),
         d5(Z, Z, Z, Z, Z), 1'b0);

    step("payload", h5(ZH, ZH, ZH, ZH, ZH), d5(PAY, PAY, PAY, PAY, Z),
         h5(ZH, ZH, ZH, ZH, ZH), d5(PAY, PAY, PAY, Z, PAY), 1'b1);

    step("inject", h5(28'h8000001, ZH, ZH, ZH, 28'h8010007), d5(Z, Z, Z, Z, Z),
         h5(ZH, inc(28'h8010007), ZH, ZH, inc(28'h8000001)), d5(Z, Z, Z, Z, Z), 1'b1);

    step("tie", h5(ZH, 28'h8010005, ZH, 28'h8010005, ZH), d5(PA, Z, Z, Z, PB),
         h5(inc(28'h8010005), inc(28'h8010005), ZH, ZH, ZH), d5(Z, PB, Z, Z, PA), 1'b1);

    step("sat", h5(ZH, ZH, 28'h800ffff, ZH, ZH), d5(Z, PC, Z, PD, Z),
         h5(ZH, ZH, ZH, ZH, 28'h800ffff), d5(PD, PC, Z, Z, Z), 1'b1);

    // Four local flits: oldest ejects, the rest deflect; injection must wait.
    step("ldefl", h5(28'h8000003, 28'h8000002, 28'h8000001, 28'h8000004, 28'h8010009),
         d5(Z, Z, PE, Z, Z),
         h5(inc(28'h8000003), inc(28'h8000002), inc(28'h8000001), ZH, inc(28'h8000004)),
         d5(Z, Z, Z, Z, PE), 1'b0);

    step("steer", h5(28'h8000001, ZH, ZH, ZH, ZH), d5(PA, PB, PC, PD, PE),
         h5(ZH, ZH, ZH, ZH, inc(28'h8000001)), d5(PA, PB, PC, Z, PD), 1'b1);

    // Reset mid-operation while the previous payload is pending.
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      ci[k] = '0;
      di[k] = PE;
    end
    #2 rst = 1'b0;
    #1 chk_zero("midrst");
    @(posedge clk);
    #1 chk_zero("midrst_hold");
    @(negedge clk);
    rst = 1'b1;

    step("postrst", h5(ZH, ZH, ZH, ZH, ZH), d5(PE, PE, PE, PE, PE),
         h5(ZH, ZH, ZH, ZH, ZH), d5(Z, Z, Z, Z, Z), 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/b_router.md
# b_router

Bufferless deflection (BLESS) router with oldest-first arbitration for a 2D mesh node. Every cycle it takes up to four network flit headers plus one local injection header. It assigns each header to a distinct output port, preferring its dimension-order productive port and deflecting losers. It registers the result, and the payload that follows one cycle later is steered through the same assignment. No flit is ever buffered or dropped once it is accepted.

## Interface
- X, default 0: this router's column.
- Y, default 0: this router's row.
- clk, in, 1: single clock, rising-edge.
- rst, in, 1: asynchronous, active-low reset.
- portN_ci, in, 28, N=0..4: header in. Ports: 0=N, 1=E, 2=S, 3=W, 4=local injection.
- portN_di, in, 128, N=0..4: payload in, one cycle after its header.
- portN_co, out, 28, N=0..4: header out. Port 4 is ejection.
- portN_do, out, 128, N=0..4: payload out, one cycle after its header out.
- port4_ready, out, 1: the injection header on port4_ci is accepted this cycle.

## Operation
- Header fields:
  - [27] valid
  - [26:24] reserved, passed through unchanged
  - [23:20] dest_y
  - [19:16] dest_x
  - [15:0] age (larger means older)
- Route computation, per valid header:
  - dest_x>X → E
  - dest_x<X → W
  - otherwise dest_y>Y → S
  - otherwise dest_y<Y → N
  - otherwise local (eject)
- Priority: higher age wins. On equal age, the lower input index wins.
- Allocation order: network headers in priority order first, then the injection header.
- Each header takes its productive port if that port is free. Otherwise it takes the lowest-index free port among 0..3.
- A local-destined header takes port 4 only if no higher-priority header already holds it; otherwise it is deflected like any other header.
- port4_ready is combinational: it is 1 when fewer than four of port0..3_ci are valid.
- An injection header with ready=0 is ignored; the source holds it and retries.
- The injection header is never sent to port 4.
- Output headers carry every field unchanged except age (see Configuration).
- Unassigned outputs drive all-zero headers.
- Payload: the assignment from cycle t is stored in a crossbar-select register. At edge t+1, portK_do <= portJ_di for each assigned pair (J→K). Unassigned outputs get zero.
- Headers with valid=0 are never routed. Their fields are ignored.

## Timing
- Header latency: 1 cycle. portK_co is registered at the edge following portJ_ci.
- Payload latency: 1 cycle after the header, 2 cycles after the header input.
- Back-to-back headers on consecutive cycles are supported. Header and payload stages overlap.
- Reset values:
  - all *_co = 0 and all *_do = 0
  - crossbar-select register = none
  - port4_ready reflects its inputs combinationally
- Reset asserted mid-operation clears all registers immediately. In-flight payloads are lost.

## Configuration
- AGE_INC_EN defined: output age = input age + 1, saturating at 16'hFFFF. This applies to ejected flits too.
- AGE_INC_EN undefined: age passes through unchanged.

## Structure
- Shared package holds:
  - header/payload widths (28/128)
  - field bit positions
  - port index constants N/E/S/W/L
- One sub-module, b_router_route: takes a header plus X/Y and returns a productive-port one-hot and a local flag. It is instantiated five times.
- Priority sort, allocation and both pipeline registers live in the top.

## Test plan
Expected values below assume AGE_INC_EN is defined.
- Reset: hold rst=0 while toggling inputs → all outputs 0. Release, then drive idle inputs → outputs stay 0.
- Four-way contention at X=Y=0:
  - Stimulus: inputs 0..3 = 8000001, 8040002, 8090003, 80f0004.
  - Next cycle: co0=8090004, co1=80f0005, co2=8040003, co3=0, co4=8000002.
  - With all four inputs valid, port4_ready=0 during the stimulus cycle.
- Payload follow: after the contention case, drive all four di=0123456789abcdef0123456789abcdef.
  - Next edge: those four do ports carry the value, do3=0.
- Injection: port0_ci=8000001 (local), port4_ci=8010007, others idle.
  - port4_ready=1.
  - Outputs: co1=8010008 (E), co4=8000002.
- Age tie: inputs 1 and 3 both 8010005 (both want E).
  - Input 1 gets E.
  - Input 3 deflects to port 0.
- Saturation: age FFFF in → age FFFF out.
